// File: rtl/freqdiv_pkg.sv
// freqdiv_pkg: shared constants for the freqdiv_bank clock-enable generator.
//   MODE_SQUARE / MODE_TICK : per-channel output mode encodings
//   DEF_*                   : default parameter values for the bank
//   ch_width()              : channel-select width for a given channel count
package freqdiv_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_TICK   = 1'b1;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_DIV_W     = 8;
  localparam int DEF_RESET_DIV = 100;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freqdiv_bank_if.sv
// freqdiv_bank_if: divisor-load bus of freqdiv_bank.
//   load      1 cycle write strobe
//   load_ch   target channel of the write
//   load_div  new divisor value
//   pending   per-channel flag: shadow divisor waiting for a period boundary
// master drives the write side, slave is the bank.
interface freqdiv_bank_if #(
  parameter int N_CH  = freqdiv_pkg::DEF_N_CH,
  parameter int DIV_W = freqdiv_pkg::DEF_DIV_W
);
  import freqdiv_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             load;
  logic [CH_W-1:0]  load_ch;
  logic [DIV_W-1:0] load_div;
  logic [N_CH-1:0]  pending;

  modport master (output load, load_ch, load_div, input pending);
  modport slave  (input load, load_ch, load_div, output pending);

endinterface

// File: rtl/freqdiv_chan.sv
// freqdiv_chan: one divider channel with double-buffered divisor.
//   clk, rst_n  system clock, async active-low reset
//   en          run enable (0: counter held at 0, output 0)
//   mode        MODE_SQUARE or MODE_TICK
//   restart     synchronous phase-align, counter back to 0
//   load        write strobe for this channel, load_div the value
//   div_out     registered divided output
//   pending     shadow divisor waiting for a period boundary
module freqdiv_chan import freqdiv_pkg::*; #(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             restart,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             div_out,
  output logic             pending
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] act_div, act_nxt;
  logic [DIV_W-1:0] shd_div, shd_nxt;
  logic             pend_nxt;
  logic             out_nxt;
  // run_q: cnt holds a live count. The first enabled edge starts at cnt=0
  // rather than incrementing, so the first period is a full one.
  logic             run_q, run_nxt;
  logic             wrap, boundary;

  always_comb begin
    wrap     = run_q && en && (cnt == act_div - ONE);
    // Any point where the period may legally change: a wrap, a restart,
    // or a channel that is not currently counting.
    boundary = wrap || restart || !en || !run_q;

    act_nxt  = act_div;
    shd_nxt  = shd_div;
    pend_nxt = pending;
    if (load) begin
      shd_nxt = load_div;
      if (boundary) begin
        act_nxt  = load_div;
        pend_nxt = 1'b0;
      end else begin
        pend_nxt = 1'b1;
      end
    end else if (pending && boundary) begin
      act_nxt  = shd_div;
      pend_nxt = 1'b0;
    end

    run_nxt = en && (act_nxt != '0);

    if (!run_nxt || !run_q || restart || wrap) cnt_nxt = '0;
    else                                       cnt_nxt = cnt + ONE;

    // Output is computed from next-state values so it lines up with cnt.
    out_nxt = 1'b0;
    if (run_nxt) begin
      if (mode == MODE_TICK) out_nxt = (cnt_nxt == act_nxt - ONE);
      else                   out_nxt = (cnt_nxt < (act_nxt >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      act_div <= RST_DIV;
      shd_div <= RST_DIV;
      pending <= 1'b0;
      div_out <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      act_div <= act_nxt;
      shd_div <= shd_nxt;
      pending <= pend_nxt;
      div_out <= out_nxt;
      run_q   <= run_nxt;
    end
  end

endmodule

// File: rtl/freqdiv_bank.sv
// freqdiv_bank: N_CH programmable clock-enable dividers.
//   clk, rst_n  system clock, async active-low reset
//   en, mode    per-channel run enable and output mode
//   restart     clears all channel counters (phase align)
//   bus         divisor-load bus (load, load_ch, load_div in; pending out)
//   div_out     per-channel registered divided output
// Writes to load_ch >= N_CH are dropped.
module freqdiv_bank import freqdiv_pkg::*; #(
  parameter int N_CH      = DEF_N_CH,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] mode,
  input  logic            restart,
  freqdiv_bank_if.slave   bus,
  output logic [N_CH-1:0] div_out
);

  logic [N_CH-1:0] load_vec;
  logic [N_CH-1:0] pend_vec;

  always_comb begin
    load_vec = '0;
    if (bus.load && (int'(bus.load_ch) < N_CH)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (int'(bus.load_ch) == i) load_vec[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    freqdiv_chan #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .mode     (mode[g]),
      .restart  (restart),
      .load     (load_vec[g]),
      .load_div (bus.load_div),
      .div_out  (div_out[g]),
      .pending  (pend_vec[g])
    );
  end

  assign bus.pending = pend_vec;

endmodule

// File: tb/tb_freqdiv_bank.sv
module tb_freqdiv_bank;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] mode;
  logic            restart;
  logic [N_CH-1:0] div_out;

  int total = 0;
  int bad   = 0;

  freqdiv_bank_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  freqdiv_bank #(.N_CH(N_CH), .DIV_W(DIV_W), .RESET_DIV(100)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .restart (restart),
    .bus     (bus),
    .div_out (div_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_load(input logic [1:0] ch, input logic [DIV_W-1:0] div);
    bus.load     = 1'b1;
    bus.load_ch  = ch;
    bus.load_div = div;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = '0; mode = '0; restart = 1'b0;
    bus.load = 1'b0; bus.load_ch = '0; bus.load_div = '0;
    repeat (3) step();
    chk("rst_out", 32'(div_out), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    rst_n = 1'b1;
    step();
    chk("idle_out", 32'(div_out), 0);

    // ch0 square with reset divisor 100: 50 high, 50 low, three periods
    en = 3'b001;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 100; i++) begin
        step();
        chk("sq100", 32'(div_out[0]), 32'(i < 50));
        chk("sq100_pend", 32'(bus.pending), 0);
      end
    end

    // load 10 at cnt=30: old period completes, then 10-cycle periods
    repeat (31) step();
    do_load(2'd0, 8'd10);
    chk("pend_rise", 32'(bus.pending[0]), 1);
    for (int i = 0; i < 68; i++) begin
      step();
      chk("pend_hold", 32'(bus.pending[0]), 1);
      chk("old_div", 32'(div_out[0]), 32'((32 + i) < 50));
    end
    for (int j = 0; j < 20; j++) begin
      step();
      chk("div10", 32'(div_out[0]), 32'((j % 10) < 5));
      chk("div10_pend", 32'(bus.pending[0]), 0);
    end

    // load 6 exactly on the wrap cycle: applied immediately
    do_load(2'd0, 8'd6);
    chk("ldwrap_pend", 32'(bus.pending[0]), 0);
    chk("ldwrap_out", 32'(div_out[0]), 1);
    for (int j = 1; j < 12; j++) begin
      step();
      chk("div6", 32'(div_out[0]), 32'((j % 6) < 3));
    end

    // ch1 tick, divisor 4, loaded while disabled
    mode = 3'b010;
    do_load(2'd1, 8'd4);
    chk("ch1_ld_pend", 32'(bus.pending[1]), 0);
    en = 3'b011;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("tick4", 32'(div_out[1]), 32'((k % 4) == 3));
    end

    // divisor 0 stops the channel
    do_load(2'd0, 8'd0);
    repeat (8) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("div0_out", 32'(div_out[0]), 0);
      chk("div0_pend", 32'(bus.pending[0]), 0);
    end

    // divisor 1: square constant 0, tick constant 1
    do_load(2'd0, 8'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("div1_sq", 32'(div_out[0]), 0);
    end
    mode = 3'b011;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("div1_tick", 32'(div_out[0]), 1);
    end

    // ch0 div 6, ch1 div 9, square, then restart aligns them
    mode = 3'b000;
    do_load(2'd0, 8'd6);
    do_load(2'd1, 8'd9);
    repeat (12) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_align", 32'(div_out[1:0]), 3);
    for (int j = 1; j < 18; j++) begin
      step();
      chk("rs_ch0", 32'(div_out[0]), 32'((j % 6) < 3));
      chk("rs_ch1", 32'(div_out[1]), 32'((j % 9) < 4));
    end

    // write to a channel that does not exist is dropped
    bus.load = 1'b1; bus.load_ch = 2'd3; bus.load_div = 8'd2;
    step();
    bus.load = 1'b0;
    chk("bad_ch_pend", 32'(bus.pending), 0);
    chk("bad_ch_ch0", 32'(div_out[0]), 32'((18 % 6) < 3));
    chk("bad_ch_ch1", 32'(div_out[1]), 32'((18 % 9) < 4));
    for (int j = 19; j < 36; j++) begin
      step();
      chk("bad_ch_run0", 32'(div_out[0]), 32'((j % 6) < 3));
      chk("bad_ch_run1", 32'(div_out[1]), 32'((j % 9) < 4));
    end

    // reset asserted mid-count clears outputs without a clock edge
    rst_n = 1'b0; en = '0;
    step();
    rst_n = 1'b1;
    step();
    en = 3'b001;
    repeat (20) step();
    en = 3'b011;
    repeat (38) step();
    chk("pre_rst", 32'(div_out), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(div_out), 0);
    chk("async_rst_pend", 32'(bus.pending), 0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 100; j++) begin
      step();
      chk("post_rst0", 32'(div_out[0]), 32'(j < 50));
      chk("post_rst1", 32'(div_out[1]), 32'(j < 50));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
